// File: rtl/xadc_drp_arbiter_if.sv
// Requester-side bus of the XADC DRP arbiter: per-requester request, address,
// write data and we, plus the shared grant/ack/err/rdata return path.
interface xadc_drp_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    req_we;
    logic [7*NUM_REQ-1:0]  req_addr;
    logic [16*NUM_REQ-1:0] req_di;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    ack;
    logic                  err;
    logic [15:0]           rdata;

    modport master (
        output req, req_we, req_addr, req_di,
        input  gnt, ack, err, rdata
    );

    modport slave (
        input  req, req_we, req_addr, req_di,
        output gnt, ack, err, rdata
    );
endinterface

// File: rtl/xadc_drp_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto the single XADC DRP
// port, with a DRDY timeout so a hung access cannot lock out the others.
module xadc_drp_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                dclk,
    input  logic                reset,
    xadc_drp_arbiter_if.slave   rq,
    output logic                busy,
    output logic [7:0]          timeout_count,
    output logic                drp_den,
    output logic                drp_dwe,
    output logic [6:0]          drp_daddr,
    output logic [15:0]         drp_di,
    input  logic [15:0]         drp_do,
    input  logic                drp_drdy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t               state_reg, state_next;
    logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
    logic [NUM_REQ-1:0]   ack_reg, ack_next;
    logic                 err_reg, err_next;
    logic [15:0]          rdata_reg, rdata_next;
    logic                 busy_reg, busy_next;
    logic [7:0]           tcount_reg, tcount_next;
    logic                 den_reg, den_next;
    logic                 dwe_reg, dwe_next;
    logic [6:0]           daddr_reg, daddr_next;
    logic [15:0]          di_reg, di_next;
    logic [7:0]           cnt_reg, cnt_next;
    logic [IDX_W-1:0]     ptr_reg, ptr_next;
    logic [IDX_W-1:0]     gidx_reg, gidx_next;

    logic [6:0]           addr_arr [NUM_REQ];
    logic [15:0]          di_arr   [NUM_REQ];
    logic                 found;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W:0]       sum;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = rq.req_addr[7*gi +: 7];
            assign di_arr[gi]   = rq.req_di[16*gi +: 16];
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        gnt_next    = gnt_reg;
        ack_next    = '0;
        err_next    = err_reg;
        rdata_next  = rdata_reg;
        tcount_next = tcount_reg;
        den_next    = 1'b0;
        dwe_next    = 1'b0;
        daddr_next  = daddr_reg;
        di_next     = di_reg;
        cnt_next    = cnt_reg;
        ptr_next    = ptr_reg;
        gidx_next   = gidx_reg;
        found       = 1'b0;
        cand        = '0;
        sum         = '0;

        case (state_reg)
            S_IDLE: begin
                // Scan ptr, ptr+1, ... so the last winner goes to the back of the line
                for (int k = 0; k < NUM_REQ; k++) begin
                    sum = {1'b0, ptr_reg} + (IDX_W+1)'(k);
                    if (sum >= (IDX_W+1)'(NUM_REQ))
                        sum = sum - (IDX_W+1)'(NUM_REQ);
                    if (!found && rq.req[sum[IDX_W-1:0]]) begin
                        found = 1'b1;
                        cand  = sum[IDX_W-1:0];
                    end
                end
                if (found) begin
                    state_next     = S_ISSUE;
                    gidx_next      = cand;
                    gnt_next       = '0;
                    gnt_next[cand] = 1'b1;
                    den_next       = 1'b1;
                    dwe_next       = rq.req_we[cand];
                    daddr_next     = addr_arr[cand];
                    di_next        = di_arr[cand];
                end
            end
            S_ISSUE: begin
                cnt_next   = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (drp_drdy) begin
                    rdata_next         = drp_do;
                    err_next           = 1'b0;
                    ack_next[gidx_reg] = 1'b1;
                    state_next         = S_DONE;
                end else if (cnt_reg == 8'(TIMEOUT - 1)) begin
                    err_next           = 1'b1;
                    ack_next[gidx_reg] = 1'b1;
                    if (tcount_reg != 8'hFF)
                        tcount_next = tcount_reg + 8'd1;
                    state_next         = S_DONE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_DONE: begin
                gnt_next   = '0;
                ptr_next   = (gidx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_reg + IDX_W'(1);
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge dclk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            gnt_reg    <= '0;
            ack_reg    <= '0;
            err_reg    <= 1'b0;
            rdata_reg  <= '0;
            busy_reg   <= 1'b0;
            tcount_reg <= '0;
            den_reg    <= 1'b0;
            dwe_reg    <= 1'b0;
            daddr_reg  <= '0;
            di_reg     <= '0;
            cnt_reg    <= '0;
            ptr_reg    <= '0;
            gidx_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            ack_reg    <= ack_next;
            err_reg    <= err_next;
            rdata_reg  <= rdata_next;
            busy_reg   <= busy_next;
            tcount_reg <= tcount_next;
            den_reg    <= den_next;
            dwe_reg    <= dwe_next;
            daddr_reg  <= daddr_next;
            di_reg     <= di_next;
            cnt_reg    <= cnt_next;
            ptr_reg    <= ptr_next;
            gidx_reg   <= gidx_next;
        end
    end

    assign rq.gnt        = gnt_reg;
    assign rq.ack        = ack_reg;
    assign rq.err        = err_reg;
    assign rq.rdata      = rdata_reg;
    assign busy          = busy_reg;
    assign timeout_count = tcount_reg;
    assign drp_den       = den_reg;
    assign drp_dwe       = dwe_reg;
    assign drp_daddr     = daddr_reg;
    assign drp_di        = di_reg;
endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Directed bench for xadc_drp_arbiter: read, write, contention, timeout,
// reset mid-access and stray drdy, each with hand-computed expectations.
module tb_xadc_drp_arbiter;
    localparam int N  = 2;
    localparam int TO = 64;

    logic        dclk = 1'b0;
    logic        reset = 1'b1;
    logic        busy;
    logic [7:0]  timeout_count;
    logic        drp_den, drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = '0;
    logic        drp_drdy = 1'b0;

    int errors = 0;
    int checks = 0;
    int den_count = 0;
    int den_viol = 0;
    bit outstanding = 1'b0;

    always #5 dclk = ~dclk;

    xadc_drp_arbiter_if #(.NUM_REQ(N)) rq ();

    xadc_drp_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .dclk          (dclk),
        .reset         (reset),
        .rq            (rq),
        .busy          (busy),
        .timeout_count (timeout_count),
        .drp_den       (drp_den),
        .drp_dwe       (drp_dwe),
        .drp_daddr     (drp_daddr),
        .drp_di        (drp_di),
        .drp_do        (drp_do),
        .drp_drdy      (drp_drdy)
    );

    // Bus monitor: counts den pulses and flags a second den before an ack
    always @(negedge dclk) begin
        if (reset) begin
            outstanding = 1'b0;
        end else begin
            if (|rq.ack) outstanding = 1'b0;
            if (drp_den) begin
                den_count++;
                if (outstanding) den_viol++;
                outstanding = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        rq.req = '0;
        drp_drdy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        rq.req = '0; rq.req_we = '0; rq.req_addr = '0; rq.req_di = '0;
        apply_reset();
        checks++;
        if ({rq.gnt, rq.ack, rq.err, rq.rdata, busy, timeout_count} !== 30'd0) begin
            errors++;
            $display("FAIL reset_status: got gnt=%b ack=%b err=%b rdata=%h busy=%b tc=%0d expected all 0",
                     rq.gnt, rq.ack, rq.err, rq.rdata, busy, timeout_count);
        end
        checks++;
        if ({drp_den, drp_dwe, drp_daddr, drp_di} !== 25'd0) begin
            errors++;
            $display("FAIL reset_drp: got den=%b dwe=%b daddr=%h di=%h expected all 0",
                     drp_den, drp_dwe, drp_daddr, drp_di);
        end
        $display("txn reset done");
    endtask

    task automatic test_read();
        int c0;
        c0 = den_count;
        rq.req_we[0] = 1'b0; rq.req_addr[6:0] = 7'h00; rq.req[0] = 1'b1;
        tick();
        checks++;
        if ({rq.gnt, drp_den, drp_dwe, drp_daddr, busy} !== {2'b01, 1'b1, 1'b0, 7'h00, 1'b1}) begin
            errors++;
            $display("FAIL read_issue: got gnt=%b den=%b dwe=%b daddr=%h busy=%b expected 01 1 0 00 1",
                     rq.gnt, drp_den, drp_dwe, drp_daddr, busy);
        end
        tick();
        checks++;
        if (drp_den !== 1'b0) begin
            errors++; $display("FAIL read_den_single: got den=%b expected 0", drp_den);
        end
        tick();
        drp_do = 16'hB5ED; drp_drdy = 1'b1;
        tick();
        drp_drdy = 1'b0;
        checks++;
        if ({rq.ack, rq.rdata, rq.err} !== {2'b01, 16'hB5ED, 1'b0}) begin
            errors++;
            $display("FAIL read_ack: got ack=%b rdata=%h err=%b expected 01 b5ed 0", rq.ack, rq.rdata, rq.err);
        end
        rq.req[0] = 1'b0;
        tick();
        checks++;
        if ({rq.ack, rq.gnt, busy} !== 5'b0) begin
            errors++;
            $display("FAIL read_idle: got ack=%b gnt=%b busy=%b expected 00 00 0", rq.ack, rq.gnt, busy);
        end
        checks++;
        if (den_count - c0 !== 1) begin
            errors++; $display("FAIL read_den_count: got %0d expected 1", den_count - c0);
        end
        $display("txn read req0 addr=00 rdata=%h err=%b", rq.rdata, rq.err);
    endtask

    task automatic test_write();
        rq.req_we[1] = 1'b1; rq.req_addr[13:7] = 7'h50; rq.req_di[31:16] = 16'hB5ED; rq.req[1] = 1'b1;
        tick();
        checks++;
        if ({rq.gnt, drp_den, drp_dwe, drp_daddr, drp_di} !== {2'b10, 1'b1, 1'b1, 7'h50, 16'hB5ED}) begin
            errors++;
            $display("FAIL write_issue: got gnt=%b den=%b dwe=%b daddr=%h di=%h expected 10 1 1 50 b5ed",
                     rq.gnt, drp_den, drp_dwe, drp_daddr, drp_di);
        end
        tick();
        checks++;
        if ({drp_den, drp_dwe, drp_daddr, drp_di} !== {1'b0, 1'b0, 7'h50, 16'hB5ED}) begin
            errors++;
            $display("FAIL write_after_issue: got den=%b dwe=%b daddr=%h di=%h expected 0 0 50 b5ed",
                     drp_den, drp_dwe, drp_daddr, drp_di);
        end
        drp_do = 16'h7777; drp_drdy = 1'b1;
        tick();
        drp_drdy = 1'b0;
        checks++;
        if ({rq.ack, rq.err, rq.rdata} !== {2'b10, 1'b0, 16'h7777}) begin
            errors++;
            $display("FAIL write_ack: got ack=%b err=%b rdata=%h expected 10 0 7777", rq.ack, rq.err, rq.rdata);
        end
        rq.req[1] = 1'b0; rq.req_we[1] = 1'b0;
        tick();
        $display("txn write req1 addr=50 di=b5ed err=%b", rq.err);
    endtask

    task automatic test_contention();
        int n;
        int e;
        logic [1:0] expv;
        apply_reset();
        rq.req_we = '0; rq.req_addr[6:0] = 7'h01; rq.req_addr[13:7] = 7'h02;
        rq.req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            e = i % 2;
            expv = 2'b01 << e;
            n = 0;
            while (!drp_den && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if ({drp_den, rq.gnt, drp_daddr} !== {1'b1, expv, 7'(e + 1)}) begin
                errors++;
                $display("FAIL contention_grant%0d: got den=%b gnt=%b daddr=%h expected 1 %b %h",
                         i, drp_den, rq.gnt, drp_daddr, expv, 7'(e + 1));
            end
            tick();
            drp_do = 16'h1000 + 16'(i); drp_drdy = 1'b1;
            tick();
            drp_drdy = 1'b0;
            checks++;
            if ({rq.ack, rq.rdata} !== {expv, 16'h1000 + 16'(i)}) begin
                errors++;
                $display("FAIL contention_ack%0d: got ack=%b rdata=%h expected %b %h",
                         i, rq.ack, rq.rdata, expv, 16'h1000 + 16'(i));
            end
            $display("txn contention %0d gnt=%b rdata=%h", i, expv, rq.rdata);
            rq.req[e] = 1'b0;
            tick();
            rq.req[e] = 1'b1;
        end
        rq.req = '0;
        tick();
        tick();
        checks++;
        if (den_viol !== 0) begin
            errors++; $display("FAIL contention_overlap: got %0d overlapping den expected 0", den_viol);
        end
    endtask

    task automatic test_timeout();
        rq.req_we[0] = 1'b0; rq.req_addr[6:0] = 7'h03; rq.req[0] = 1'b1;
        tick();
        tick();
        for (int i = 1; i < TO; i++) tick();
        checks++;
        if (rq.ack !== 2'b00) begin
            errors++; $display("FAIL timeout_early: got ack=%b one cycle before timeout expected 00", rq.ack);
        end
        tick();
        checks++;
        if ({rq.ack, rq.err, timeout_count, rq.rdata} !== {2'b01, 1'b1, 8'd1, 16'h1003}) begin
            errors++;
            $display("FAIL timeout_ack: got ack=%b err=%b tc=%0d rdata=%h expected 01 1 1 1003",
                     rq.ack, rq.err, timeout_count, rq.rdata);
        end
        rq.req[0] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        drp_do = 16'hDEAD; drp_drdy = 1'b1;
        tick();
        drp_drdy = 1'b0;
        tick();
        checks++;
        if ({rq.ack, rq.err, rq.rdata, busy, drp_den, timeout_count} !== {2'b00, 1'b1, 16'h1003, 1'b0, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL timeout_late_drdy: got ack=%b err=%b rdata=%h busy=%b den=%b tc=%0d expected 00 1 1003 0 0 1",
                     rq.ack, rq.err, rq.rdata, busy, drp_den, timeout_count);
        end
        $display("txn timeout req0 err=%b timeout_count=%0d", rq.err, timeout_count);
    endtask

    task automatic test_reset_in_wait();
        rq.req_we[0] = 1'b0; rq.req_addr[6:0] = 7'h13; rq.req[0] = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({rq.gnt, rq.ack, rq.err, rq.rdata, busy, timeout_count, drp_den, drp_dwe, drp_daddr, drp_di} !== 55'd0) begin
            errors++;
            $display("FAIL reset_wait_outputs: got gnt=%b ack=%b err=%b rdata=%h busy=%b tc=%0d den=%b daddr=%h expected all 0",
                     rq.gnt, rq.ack, rq.err, rq.rdata, busy, timeout_count, drp_den, drp_daddr);
        end
        reset = 1'b0; rq.req[0] = 1'b0;
        rq.req_we[1] = 1'b0; rq.req_addr[13:7] = 7'h06; rq.req[1] = 1'b1;
        tick();
        checks++;
        if ({rq.gnt, drp_den, drp_dwe, drp_daddr} !== {2'b10, 1'b1, 1'b0, 7'h06}) begin
            errors++;
            $display("FAIL reset_wait_regrant: got gnt=%b den=%b dwe=%b daddr=%h expected 10 1 0 06",
                     rq.gnt, drp_den, drp_dwe, drp_daddr);
        end
        tick();
        drp_do = 16'h0ABC; drp_drdy = 1'b1;
        tick();
        drp_drdy = 1'b0;
        checks++;
        if ({rq.ack, rq.rdata, rq.err} !== {2'b10, 16'h0ABC, 1'b0}) begin
            errors++;
            $display("FAIL reset_wait_read: got ack=%b rdata=%h err=%b expected 10 0abc 0", rq.ack, rq.rdata, rq.err);
        end
        rq.req[1] = 1'b0;
        tick();
        $display("txn post-reset read req1 addr=06 rdata=%h", rq.rdata);
    endtask

    task automatic test_stray_drdy();
        drp_do = 16'h1234; drp_drdy = 1'b1;
        tick();
        drp_drdy = 1'b0;
        tick();
        checks++;
        if ({rq.rdata, rq.ack, rq.err, busy, drp_den} !== {16'h0ABC, 2'b00, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stray_drdy: got rdata=%h ack=%b err=%b busy=%b den=%b expected 0abc 00 0 0 0",
                     rq.rdata, rq.ack, rq.err, busy, drp_den);
        end
        $display("txn stray drdy rdata=%h", rq.rdata);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_timeout();
        test_reset_in_wait();
        test_stray_drdy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
